lsu_mem_stage: RTL and testbench

- Memory stage that sits directly downstream of the execute ALU and consumes its 32-bit result.
- For loads and stores, the ALU result is the effective address. The block drives a req/gnt/rvalid data-memory port, builds byte enables and replicated store data, and aligns and extends load data.
- Non-memory ops pass the ALU result through unchanged.
- Output is one registered writeback beat per accepted op.

---
 rtl/lsu_mem_stage_if.sv | 41 ++++
 rtl/lsu_mem_stage.sv | 187 ++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// EX-side handshake, data-memory port and writeback bundle for lsu_mem_stage.
// master = surroundings (EX, memory, testbench); slave = the memory stage itself.
interface lsu_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_out;
  logic [31:0] in_rs2;
  logic [2:0]  in_funct3;
  logic        in_is_load;
  logic        in_is_store;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_data;
  logic        out_err;
  logic        out_misalign;

  modport master (
    output in_valid, in_alu_out, in_rs2, in_funct3, in_is_load, in_is_store, in_rd, in_rd_we,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  out_valid, out_rd, out_rd_we, out_data, out_err, out_misalign
  );

  modport slave (
    input  in_valid, in_alu_out, in_rs2, in_funct3, in_is_load, in_is_store, in_rd, in_rd_we,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output out_valid, out_rd, out_rd_we, out_data, out_err, out_misalign
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: req/gnt/rvalid data port, lane steering, load extension.
// Optional MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of issuing them.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rst,
  lsu_mem_stage_if.slave bus
);
  // state  | meaning
  // S_IDLE | ready for an op; non-memory ops complete from here
  // S_REQ  | mem_req held with stable address/be/data until mem_gnt
  // S_WAIT | load granted, waiting for mem_rvalid or timeout
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_rs2;
  logic [31:0] r_cnt;
  logic [2:0]  r_funct3;
  logic        r_is_load;
  logic [4:0]  r_rd;
  logic        r_rd_we;
  logic        r_out_valid;
  logic [4:0]  r_out_rd;
  logic        r_out_rd_we;
  logic [31:0] r_out_data;
  logic        r_out_err;
  logic        r_out_misalign;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_misalign;
  logic        w_timeout;
  logic        w_req;
  logic [1:0]  w_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  assign w_accept  = bus.in_valid && (r_state == S_IDLE);
  assign w_is_mem  = bus.in_is_load || bus.in_is_store;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
  assign w_req     = (r_state == S_REQ);
  assign w_off     = r_addr[1:0];

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((bus.in_funct3[1:0] == 2'b01) && bus.in_alu_out[0]) ||
                      (bus.in_funct3[1] && (bus.in_alu_out[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_rs2;
    case (r_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{r_rs2[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {w_off[1], 1'b0};
        w_wdata = {2{r_rs2[15:0]}};
      end
      default: ;
    endcase
    if (r_is_load) w_wdata = 32'd0;
  end

  always_comb begin
    case (w_off)
      2'd0:    w_byte = bus.mem_rdata[7:0];
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    w_half = w_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus.mem_rdata;
    endcase
  end

  assign bus.in_ready     = (r_state == S_IDLE);
  assign bus.mem_req      = w_req;
  assign bus.mem_we       = w_req && !r_is_load;
  assign bus.mem_addr     = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign bus.mem_be       = w_req ? w_be : 4'd0;
  assign bus.mem_wdata    = w_req ? w_wdata : 32'd0;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_rd       = r_out_rd;
  assign bus.out_rd_we    = r_out_rd_we;
  assign bus.out_data     = r_out_data;
  assign bus.out_err      = r_out_err;
  assign bus.out_misalign = r_out_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_addr         <= 32'd0;
      r_rs2          <= 32'd0;
      r_cnt          <= 32'd0;
      r_funct3       <= 3'd0;
      r_is_load      <= 1'b0;
      r_rd           <= 5'd0;
      r_rd_we        <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_rd       <= 5'd0;
      r_out_rd_we    <= 1'b0;
      r_out_data     <= 32'd0;
      r_out_err      <= 1'b0;
      r_out_misalign <= 1'b0;
    end else begin
      r_out_valid    <= 1'b0;
      r_out_err      <= 1'b0;
      r_out_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_is_mem) begin
              r_out_valid <= 1'b1;
              r_out_data  <= bus.in_alu_out;
              r_out_rd    <= bus.in_rd;
              r_out_rd_we <= bus.in_rd_we;
            end else if (w_misalign) begin
              r_out_valid    <= 1'b1;
              r_out_misalign <= 1'b1;
              r_out_data     <= bus.in_alu_out;
              r_out_rd       <= bus.in_rd;
              r_out_rd_we    <= 1'b0;
            end else begin
              r_addr    <= bus.in_alu_out;
              r_rs2     <= bus.in_rs2;
              r_funct3  <= bus.in_funct3;
              r_is_load <= bus.in_is_load;
              r_rd      <= bus.in_rd;
              r_rd_we   <= bus.in_rd_we;
              r_state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            if (r_is_load) begin
              r_cnt   <= 32'd0;
              r_state <= S_WAIT;
            end else begin
              r_out_valid <= 1'b1;
              r_out_data  <= 32'd0;
              r_out_rd    <= r_rd;
              r_out_rd_we <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          // rvalid takes priority over a timeout landing on the same cycle
          if (bus.mem_rvalid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_load;
            r_out_rd    <= r_rd;
            r_out_rd_we <= r_rd_we;
            r_state     <= S_IDLE;
          end else if (w_timeout) begin
            r_out_valid <= 1'b1;
            r_out_err   <= 1'b1;
            r_out_data  <= 32'd0;
            r_out_rd    <= r_rd;
            r_out_rd_we <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed plus randomized bench for lsu_mem_stage, checked against an arithmetic reference model.
module tb_lsu_mem_stage;
  localparam int TO = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (f3 % 4 == 0) return 32'(1 << off);
    if (f3 % 4 == 1) return 32'(3 << ((off / 2) * 2));
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2, input logic ld);
    if (ld) return 32'd0;
    if (f3 % 4 == 0) return (rs2 % 256) * 32'h0101_0101;
    if (f3 % 4 == 1) return (rs2 % 65536) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    int unsigned off = addr % 4;
    logic [31:0] b = (rdata >> (8 * off)) % 256;
    logic [31:0] h = (rdata >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5: return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
    if (f3 % 4 == 1) return (addr % 2) != 0;
    if (f3 % 4 >= 2) return (addr % 4) != 0;
`endif
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_alu_out = 0; bus.in_rs2 = 0; bus.in_funct3 = 0;
    bus.in_is_load = 0; bus.in_is_store = 0; bus.in_rd = 0; bus.in_rd_we = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
  endtask

  // Offers one op in the current (IDLE) cycle and follows it to its writeback beat.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic rd_we,
                        input int gd, input int rv_dly, input logic [31:0] rdata);
    logic [31:0] eaddr = {addr[31:2], 2'b00};
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1; bus.in_alu_out = addr; bus.in_rs2 = rs2; bus.in_funct3 = f3;
    bus.in_is_load = ld; bus.in_is_store = st; bus.in_rd = rd; bus.in_rd_we = rd_we;
    tick();
    bus.in_valid = 0;
    if (!ld && !st) begin
      chk("alu_valid", 32'(bus.out_valid), 32'd1);
      chk("alu_data", bus.out_data, addr);
      chk("alu_rd", 32'(bus.out_rd), 32'(rd));
      chk("alu_rd_we", 32'(bus.out_rd_we), 32'(rd_we));
      chk("alu_no_req", 32'(bus.mem_req), 32'd0);
      return;
    end
    if (m_mis(f3, addr)) begin
      chk("mis_valid", 32'(bus.out_valid), 32'd1);
      chk("mis_flag", 32'(bus.out_misalign), 32'd1);
      chk("mis_data", bus.out_data, addr);
      chk("mis_rd_we", 32'(bus.out_rd_we), 32'd0);
      chk("mis_no_req", 32'(bus.mem_req), 32'd0);
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      chk("req", 32'(bus.mem_req), 32'd1);
      chk("req_addr", bus.mem_addr, eaddr);
      chk("req_be", 32'(bus.mem_be), m_be(f3, addr));
      chk("req_wdata", bus.mem_wdata, m_wdata(f3, rs2, ld));
      chk("req_we", 32'(bus.mem_we), 32'(!ld));
      chk("req_no_valid", 32'(bus.out_valid), 32'd0);
      chk("req_not_ready", 32'(bus.in_ready), 32'd0);
      bus.mem_gnt = (i == gd);
      bus.mem_rvalid = (i != gd) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_rdata = $urandom;
      tick();
    end
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    if (!ld) begin
      chk("st_valid", 32'(bus.out_valid), 32'd1);
      chk("st_rd_we", 32'(bus.out_rd_we), 32'd0);
      chk("st_err", 32'(bus.out_err), 32'd0);
      chk("st_mis", 32'(bus.out_misalign), 32'd0);
      return;
    end
    chk("wait_no_req", 32'(bus.mem_req), 32'd0);
    if (rv_dly < TO) begin
      for (int i = 0; i < rv_dly; i++) begin
        chk("wait_no_valid", 32'(bus.out_valid), 32'd0);
        tick();
      end
      bus.mem_rvalid = 1; bus.mem_rdata = rdata;
      tick();
      bus.mem_rvalid = 0; bus.mem_rdata = $urandom;
      chk("ld_valid", 32'(bus.out_valid), 32'd1);
      chk("ld_data", bus.out_data, m_load(f3, addr, rdata));
      chk("ld_rd", 32'(bus.out_rd), 32'(rd));
      chk("ld_rd_we", 32'(bus.out_rd_we), 32'(rd_we));
      chk("ld_err", 32'(bus.out_err), 32'd0);
    end else begin
      for (int i = 0; i < TO; i++) begin
        chk("to_no_valid", 32'(bus.out_valid), 32'd0);
        tick();
      end
      chk("to_valid", 32'(bus.out_valid), 32'd1);
      chk("to_err", 32'(bus.out_err), 32'd1);
      chk("to_data", bus.out_data, 32'd0);
      chk("to_rd_we", 32'(bus.out_rd_we), 32'd0);
    end
    chk("done_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic ld, st;
    logic [2:0] f3;
    checks = 0;
    failures = 0;
    rst = 1;
    idle_inputs();
    #3;
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_be", 32'(bus.mem_be), 32'd0);
    chk("rst_err", 32'(bus.out_err), 32'd0);
    tick(); tick();
    rst = 0;
    tick();

    run_op(0, 0, 3'd0, 32'h1234_5678, 32'd0, 5'd7, 1'b1, 0, 0, 0);
    run_op(0, 1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 5'd3, 1'b1, 2, 0, 0);
    run_op(1, 0, 3'd0, 32'h0000_2001, 32'd0, 5'd5, 1'b1, 0, 1, 32'h0000_8000);
    run_op(1, 0, 3'd4, 32'h0000_2001, 32'd0, 5'd5, 1'b1, 0, 0, 32'h0000_8000);
    run_op(1, 0, 3'd1, 32'h0000_2002, 32'd0, 5'd6, 1'b1, 1, 2, 32'h8001_0000);
    run_op(1, 0, 3'd2, 32'h0000_2004, 32'd0, 5'd8, 1'b1, 0, 0, 32'hCAFE_F00D);
    run_op(0, 0, 3'd0, 32'hDEAD_BEEF, 32'd0, 5'd9, 1'b1, 0, 0, 0);
    run_op(1, 0, 3'd2, 32'h0000_2008, 32'd0, 5'd10, 1'b1, 0, TO - 1, 32'h1111_2222);
    run_op(1, 0, 3'd2, 32'h0000_200C, 32'd0, 5'd11, 1'b1, 0, TO + 3, 0);
    run_op(1, 1, 3'd2, 32'h0000_2010, 32'h5555_5555, 5'd12, 1'b1, 0, 0, 32'h7777_8888);
    run_op(0, 1, 3'd2, 32'h0000_3002, 32'h0102_0304, 5'd1, 1'b0, 0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: begin ld = 0; st = 0; end
        1: begin ld = 0; st = 1; end
        2: begin ld = 1; st = 0; end
        default: begin ld = 1; st = 1; end
      endcase
      f3 = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      run_op(ld, st, f3, $urandom, $urandom, 5'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 1)), $urandom);
    end

    // reset while requesting: mem_req must drop without waiting for a clock edge
    run_op(0, 0, 3'd0, 32'h0, 32'd0, 5'd0, 1'b0, 0, 0, 0);
    bus.in_valid = 1; bus.in_is_load = 1; bus.in_funct3 = 3'd2; bus.in_alu_out = 32'h40;
    tick();
    bus.in_valid = 0;
    chk("rreq_req", 32'(bus.mem_req), 32'd1);
    #1 rst = 1;
    #1;
    chk("rreq_req_drop", 32'(bus.mem_req), 32'd0);
    chk("rreq_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst = 0;
    tick();

    // reset while waiting: a late rvalid must be ignored
    bus.in_valid = 1; bus.in_is_load = 1; bus.in_funct3 = 3'd2; bus.in_alu_out = 32'h80;
    bus.in_rd = 5'd4; bus.in_rd_we = 1;
    tick();
    bus.in_valid = 0; bus.mem_gnt = 1;
    tick();
    bus.mem_gnt = 0;
    #1 rst = 1;
    #1;
    chk("rwait_req", 32'(bus.mem_req), 32'd0);
    chk("rwait_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst = 0;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_5678;
    tick();
    bus.mem_rvalid = 0;
    chk("rwait_no_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("rwait_no_valid2", 32'(bus.out_valid), 32'd0);
    chk("rwait_idle", 32'(bus.in_ready), 32'd1);
    idle_inputs();
    run_op(0, 0, 3'd0, 32'hA5A5_0001, 32'd0, 5'd2, 1'b1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
